// File: rtl/requant_pack_if.sv
// Stream bundle for requant_pack: accumulator samples in, packed int8 words out.
interface requant_pack_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_acc;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;
  logic [2:0]         out_count;

  // Producer of samples / consumer of packed words.
  modport master (
    output in_valid, in_acc, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  // The packer itself.
  modport slave (
    input  in_valid, in_acc, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/requant_pack.sv
// Requantizing packer: acc * mult, rounding arithmetic shift, zero-point,
// int8 saturation, four lanes packed per 32-bit word (lane0 in [7:0]).
module requant_pack #(
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  requant_pack_if.slave             bus,
  input  logic signed [MULT_W-1:0]  cfg_mult,
  input  logic [SHIFT_W-1:0]        cfg_shift,
  input  logic signed [7:0]         cfg_zp,
  output logic                      busy
);

  localparam int PROD_W = 32 + MULT_W;
  localparam int RND_W  = PROD_W + 1;

  localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'(127);
  localparam logic signed [RND_W-1:0] SAT_MIN = RND_W'(-128);

  // Rounding arithmetic right shift, ties toward +inf; one guard bit keeps
  // the rounding add from overflowing.
  function automatic logic signed [RND_W-1:0] round_shift(
    input logic signed [PROD_W-1:0] p,
    input logic [SHIFT_W-1:0]       sh
  );
    logic signed [RND_W-1:0] ext;
    logic signed [RND_W-1:0] half;
    logic [SHIFT_W-1:0]      shm1;
    ext  = {p[PROD_W-1], p};
    shm1 = sh - 1'b1;
    half = RND_W'(1) <<< shm1;
    if (sh == '0) return ext;
    return (ext + half) >>> sh;
  endfunction

  // Clip to the int8 range.
  function automatic logic signed [7:0] sat8(input logic signed [RND_W-1:0] v);
    if (v > SAT_MAX) return 8'h7f;
    if (v < SAT_MIN) return 8'h80;
    return v[7:0];
  endfunction

  logic                     adv;
  logic                     in_ready_w;
  logic                     accept;

  logic                     s1_valid_q;
  logic                     last_q;
  logic signed [PROD_W-1:0] prod_q;

  logic signed [RND_W-1:0]  shifted;
  logic signed [RND_W-1:0]  biased;
  logic signed [7:0]        sat_byte;
  logic [31:0]              merged;

  logic [1:0]               lane_q,      lane_d;
  logic [31:0]              buf_q,       buf_d;
  logic                     out_valid_q, out_valid_d;
  logic [31:0]              out_data_q,  out_data_d;
  logic [2:0]               out_count_q, out_count_d;

  // Everything advances unless a finished word is stalled downstream.
  assign adv        = !out_valid_q || bus.out_ready;
  assign in_ready_w = adv && !rst;
  assign accept     = bus.in_valid && in_ready_w;

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign busy          = s1_valid_q || (lane_q != 2'd0) || out_valid_q;

  // S1 control: sample-valid and word-close flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      last_q     <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= accept;
      last_q     <= bus.in_last;
    end
  end

  // S1 data: full-precision product, only meaningful while s1_valid_q.
  always_ff @(posedge clk) begin
    if (accept) prod_q <= PROD_W'(bus.in_acc) * PROD_W'(cfg_mult);
  end

  // S2 arithmetic: round/shift, add zero-point, saturate.
  always_comb begin
    shifted  = round_shift(prod_q, cfg_shift);
    biased   = shifted + RND_W'(cfg_zp);
    sat_byte = sat8(biased);
  end

  // S2 packing: drop the byte into its lane, emit a word on lane 3 or last.
  always_comb begin
    lane_d      = lane_q;
    buf_d       = buf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    merged      = buf_q;
    merged[8*lane_q +: 8] = sat_byte;
    if (bus.out_ready) out_valid_d = 1'b0;
    if (adv && s1_valid_q) begin
      if (lane_q == 2'd3 || last_q) begin
        out_valid_d = 1'b1;
        out_data_d  = merged;
        out_count_d = {1'b0, lane_q} + 3'd1;
        lane_d      = 2'd0;
        buf_d       = '0;
      end else begin
        buf_d  = merged;
        lane_d = lane_q + 2'd1;
      end
    end
  end

  // Pack buffer and output word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q      <= 2'd0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= 3'd0;
    end else begin
      lane_q      <= lane_d;
      buf_q       <= buf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

endmodule

// File: tb/tb_requant_pack.sv
// Directed bench for requant_pack: vector table plus backpressure and reset sequences.
`timescale 1ns/1ps
module tb_requant_pack;

  logic clk = 1'b0;
  logic rst;
  logic signed [15:0] cfg_mult;
  logic [4:0]         cfg_shift;
  logic signed [7:0]  cfg_zp;
  logic               busy;

  int errors = 0;
  int checks = 0;

  requant_pack_if bus();

  requant_pack #(.MULT_W(16), .SHIFT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cfg_mult  (cfg_mult),
    .cfg_shift (cfg_shift),
    .cfg_zp    (cfg_zp),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               n;
    logic [3:0][31:0] acc;
    logic [15:0]      mult;
    logic [4:0]       sh;
    logic [7:0]       zp;
    logic [31:0]      exp_data;
    logic [2:0]       exp_cnt;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(int n, int a0, int a1, int a2, int a3,
                              int mult, int sh, int zp,
                              logic [31:0] d, int c);
    vec_t v;
    v.n        = n;
    v.acc[0]   = 32'(a0);
    v.acc[1]   = 32'(a1);
    v.acc[2]   = 32'(a2);
    v.acc[3]   = 32'(a3);
    v.mult     = 16'(mult);
    v.sh       = 5'(sh);
    v.zp       = 8'(zp);
    v.exp_data = d;
    v.exp_cnt  = 3'(c);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Send one word's worth of samples, then check latency, contents and idle.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    cfg_mult      = v.mult;
    cfg_shift     = v.sh;
    cfg_zp        = v.zp;
    bus.out_ready = 1'b1;
    for (int k = 0; k < v.n; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_acc   = v.acc[k];
      bus.in_last  = (k == v.n - 1) && (v.n < 4);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_data"},      bus.out_data,       v.exp_data);
    check({tag, "_count"},     32'(bus.out_count), 32'(v.exp_cnt));
    @(negedge clk);
    check({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_idle_busy"},  32'(busy),          32'd0);
  endtask

  // Twelve samples streamed while the first word is stalled for 5 cycles.
  task automatic bp_test();
    logic [31:0] got[$];
    logic [31:0] exp_w[3];
    exp_w[0] = 32'h04030201;
    exp_w[1] = 32'h08070605;
    exp_w[2] = 32'h0c0b0a09;
    cfg_mult      = 16'sd1;
    cfg_shift     = 5'd0;
    cfg_zp        = 8'sd0;
    bus.out_ready = 1'b1;
    fork
      begin : drv
        int i = 0;
        int g = 0;
        while (i < 12 && g < 200) begin
          @(negedge clk);
          bus.in_valid = 1'b1;
          bus.in_acc   = 32'(i + 1);
          bus.in_last  = 1'b0;
          #3;
          if (bus.in_ready) i++;
          g++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      begin : mon
        int  g = 0;
        bit  held = 1'b0;
        while (got.size() < 3 && g < 300) begin
          @(negedge clk);
          g++;
          if (bus.out_valid) begin
            if (!held) begin
              held = 1'b1;
              bus.out_ready = 1'b0;
              for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                check("bp_in_ready_low", 32'(bus.in_ready),  32'd0);
                check("bp_hold_valid",   32'(bus.out_valid), 32'd1);
              end
              bus.out_ready = 1'b1;
            end
            got.push_back(bus.out_data);
          end
        end
      end
    join
    check("bp_word_count", 32'(got.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < got.size()) check($sformatf("bp_word%0d", k), got[k], exp_w[k]);
    end
    repeat (3) @(negedge clk);
    check("bp_idle_busy",  32'(busy),          32'd0);
    check("bp_idle_valid", 32'(bus.out_valid), 32'd0);
  endtask

  // Partial word discarded by reset; the next word starts at lane0.
  task automatic reset_test();
    cfg_mult      = 16'sd1;
    cfg_shift     = 5'd0;
    cfg_zp        = 8'sd0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_acc   = 32'd9;
    @(negedge clk);
    bus.in_acc   = 32'd9;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("rst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_valid",    32'(bus.out_valid), 32'd0);
    check("rst_mid_busy",     32'(busy),          32'd0);
    check("rst_mid_in_ready", 32'(bus.in_ready),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_post_in_ready", 32'(bus.in_ready), 32'd1);
    run_vec(mk(4, 1, 1, 1, 1, 1, 0, 0, 32'h01010101, 4), 99);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = mk(4, 1, 2, 3, 4,                 1,      0,  0,   32'h04030201, 4);
    vecs[1] = mk(4, 200, -200, 127, -128,       1,      0,  0,   32'h807f807f, 4);
    vecs[2] = mk(4, 5, -5, 2, 1,                3,      2,  0,   32'h0102fc04, 4);
    vecs[3] = mk(2, 10, 0, 0, 0,                1,      0, -3,   32'h0000fd07, 2);
    vecs[4] = mk(4, 7, 3, -100, 1000,          -2,      1,  5,   32'h806902fe, 4);
    vecs[5] = mk(4, -1, 1, -3, 3,               1,      1,  0,   32'h02ff0100, 4);
    vecs[6] = mk(1, 2147483647, 0, 0, 0,        1,     31,  0,   32'h00000001, 1);
    vecs[7] = mk(1, -2147483647 - 1, 0, 0, 0,  -32768,  0,  0,   32'h0000007f, 1);
    vecs[8] = mk(2, 1, -200, 0, 0,              1,      0,  127, 32'h0000b77f, 2);
    vecs[9] = mk(3, 5, 6, 7, 0,                 1,      0,  0,   32'h00070605, 3);

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_acc    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    cfg_mult      = 16'sd1;
    cfg_shift     = 5'd0;
    cfg_zp        = 8'sd0;

    #2;
    check("reset_in_ready",  32'(bus.in_ready),  32'd0);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_data",  bus.out_data,       32'd0);
    check("reset_out_count", 32'(bus.out_count), 32'd0);
    check("reset_busy",      32'(busy),          32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_in_ready", 32'(bus.in_ready), 32'd1);

    // A lone in_last with no valid sample must not flush anything.
    @(negedge clk);
    bus.in_last = 1'b1;
    @(negedge clk);
    bus.in_last = 1'b0;
    @(negedge clk);
    check("lone_last_valid", 32'(bus.out_valid), 32'd0);
    check("lone_last_busy",  32'(busy),          32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    bp_test();
    reset_test();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
